// File: rtl/inst_fetch_pkg.sv
// Shared fetch/decode definitions: bus widths, the canonical NOP, the fetch
// state encoding and the {pc, inst} entry carried through the fetch slot.
package inst_fetch_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;

    typedef logic [INST_ADDR_BUS-1:0] inst_addr_t;
    typedef logic [INST_BUS-1:0]      inst_t;

    // addi x0, x0, 0
    localparam inst_t NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_entry_t;

    function automatic inst_addr_t word_align(input inst_addr_t addr);
        return {addr[INST_ADDR_BUS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory port, decode-side slot and redirect.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    // Handshakes: a request is held with mem_req_o=1 and a stable mem_addr_o
    // until the cycle mem_gnt_i=1; mem_rvalid_i is a one-cycle pulse with no
    // back-pressure; the slot transfers on any edge with inst_valid_o=1 and
    // stall_i=0, otherwise it is held unchanged.
    logic       mem_req_o;
    inst_addr_t mem_addr_o;
    logic       mem_gnt_i;
    logic       mem_rvalid_i;
    inst_t      mem_rdata_i;

    logic       stall_i;
    logic       br_enable_i;
    inst_addr_t br_addr_i;

    inst_addr_t pc_o;
    inst_t      inst_o;
    logic       inst_valid_o;

    modport master (
        output mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, stall_i, br_enable_i, br_addr_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, stall_i, br_enable_i, br_addr_i
    );

endinterface

// File: rtl/inst_fetch_slot_buf.sv
// Two-entry in-order buffer: the output slot seen by decode plus a hold entry
// that absorbs one response while decode is stalled.
module inst_fetch_slot_buf
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  fetch_entry_t load_entry,
    input  logic         stall,
    output logic         slot_valid,
    output fetch_entry_t slot_entry,
    output logic         hold_valid,
    output logic         consume
);

    fetch_entry_t hold_entry;

    assign consume = slot_valid && !stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid <= 1'b0;
            slot_entry <= '{pc: '0, inst: NOP_INST};
            hold_valid <= 1'b0;
            hold_entry <= '{pc: '0, inst: NOP_INST};
        end else if (flush) begin
            // pc is left as-is; only the instruction is forced back to NOP
            slot_valid      <= 1'b0;
            slot_entry.inst <= NOP_INST;
            hold_valid      <= 1'b0;
        end else if (hold_valid && consume) begin
            slot_entry <= hold_entry;
            hold_valid <= 1'b0;
        end else if (load && (!slot_valid || consume)) begin
            slot_valid <= 1'b1;
            slot_entry <= load_entry;
        end else if (load) begin
            hold_valid <= 1'b1;
            hold_entry <= load_entry;
        end else if (consume) begin
            slot_valid      <= 1'b0;
            slot_entry.inst <= NOP_INST;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory read at a time and
// hands {pc, inst} to decode, dropping responses made stale by a redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000
)
(
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus,
    output fetch_state_e dbg_state
);

    localparam inst_addr_t START_PC = word_align(RESET_PC);

    fetch_state_e state;
    inst_addr_t   pc;
    inst_addr_t   req_pc;
    logic         kill;

    logic         br;
    inst_addr_t   br_target;
    logic         slot_valid;
    logic         hold_valid;
    logic         consume;
    logic         slot_free;
    logic         rsp_load;
    fetch_entry_t slot_entry;

    assign br        = bus.br_enable_i;
    assign br_target = word_align(bus.br_addr_i);
    assign slot_free = !slot_valid || consume;
    assign rsp_load  = (state == WAIT) && bus.mem_rvalid_i && !kill && !br;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= START_PC;
            req_pc <= START_PC;
            kill   <= 1'b0;
        end else begin
            if (br) pc <= br_target;
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (bus.mem_gnt_i) begin
                        req_pc <= pc;
                        state  <= WAIT;
                        // a redirect on the grant edge orphans the fetch just issued
                        if (br) kill <= 1'b1;
                        else    pc   <= pc + 32'd4;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        kill <= 1'b0;
                        if (br || kill || slot_free) state <= REQ;
                        else                         state <= HOLD;
                    end else if (br) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (br || consume) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    inst_fetch_slot_buf u_slot_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (br),
        .load       (rsp_load),
        .load_entry ('{pc: req_pc, inst: bus.mem_rdata_i}),
        .stall      (bus.stall_i),
        .slot_valid (slot_valid),
        .slot_entry (slot_entry),
        .hold_valid (hold_valid),
        .consume    (consume)
    );

    assign bus.mem_req_o    = (state == REQ);
    assign bus.mem_addr_o   = pc;
    assign bus.pc_o         = slot_entry.pc;
    assign bus.inst_o       = slot_entry.inst;
    assign bus.inst_valid_o = slot_valid;
    assign dbg_state        = state;

    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst)
        bus.mem_addr_o[1:0] == 2'b00);

    // the hold entry exists exactly while the FSM waits for it to drain
    a_hold_tracks_state: assert property (@(posedge clk) disable iff (!rst)
        hold_valid == (state == HOLD));

    a_empty_slot_is_nop: assert property (@(posedge clk) disable iff (!rst)
        slot_valid || (slot_entry.inst == NOP_INST));

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: reactive memory model, in-order delivery scoreboard
// and directed scenarios with hand-computed slot/address values.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [31:0] RST_PC       = 32'h0000_0000;
    localparam logic [31:0] SPECIAL_PC   = 32'h0000_0010;
    localparam logic [31:0] SPECIAL_DATA = 32'hAAAA_AAAA;

    logic         clk = 1'b0;
    logic         rst;
    fetch_state_e dbg_state;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_dlv    = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] data_for(input logic [31:0] addr);
        return (addr == SPECIAL_PC) ? SPECIAL_DATA : ~addr;
    endfunction

    // memory model knobs and bookkeeping
    int unsigned gnt_delay = 0;
    int unsigned rsp_delay = 1;
    int unsigned req_cnt   = 0;
    int unsigned rsp_cnt   = 0;
    bit          outstanding = 1'b0;
    logic [31:0] gnt_addr  = '0;
    logic [31:0] out_addr  = '0;

    // scoreboard: every granted fetch is delivered in order unless a redirect follows its grant
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_pc;

    // negedge: drive memory for the coming edge, then check what that edge will do
    always @(negedge clk) begin
        if (!rst) begin
            outstanding      = 1'b0;
            req_cnt          = 0;
            rsp_cnt          = 0;
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = '0;
            exp_q.delete();
            exp_fetch        = RST_PC;
        end else begin
            if (bus.mem_rvalid_i) outstanding = 1'b0;
            if (bus.mem_gnt_i) begin
                outstanding = 1'b1;
                out_addr    = gnt_addr;
                rsp_cnt     = rsp_delay - 1;
            end
            bus.mem_rvalid_i = 1'b0;
            if (outstanding) begin
                if (rsp_cnt == 0) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = data_for(out_addr);
                end else begin
                    rsp_cnt--;
                end
            end
            bus.mem_gnt_i = 1'b0;
            if (bus.mem_req_o) begin
                if (req_cnt >= gnt_delay) begin
                    bus.mem_gnt_i = 1'b1;
                    gnt_addr      = bus.mem_addr_o;
                    req_cnt       = 0;
                end else begin
                    req_cnt++;
                end
            end

            chk("one_outstanding", 32'(bus.mem_req_o && outstanding), 32'd0);
            if (bus.mem_req_o) chk("addr_aligned", 32'(bus.mem_addr_o[1:0]), 32'd0);
            if (!bus.inst_valid_o) chk("empty_slot_nop", bus.inst_o, NOP_INST);
            else                   chk("slot_data", bus.inst_o, data_for(bus.pc_o));

            if (bus.inst_valid_o && !bus.stall_i && !bus.br_enable_i) begin
                chk("delivery_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_pc = exp_q.pop_front();
                    chk("delivery_pc", bus.pc_o, exp_pc);
                    n_dlv++;
                end
            end
            if (bus.mem_req_o && bus.mem_gnt_i) begin
                chk("fetch_addr", bus.mem_addr_o, exp_fetch);
                exp_q.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (bus.br_enable_i) begin
                exp_q.delete();
                exp_fetch = bus.br_addr_i & ~32'h3;
            end
            chk("queue_depth", 32'(exp_q.size() <= 2), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string name, input logic valid, input logic [31:0] pc, input logic [31:0] inst);
        chk({name, "_valid"}, 32'(bus.inst_valid_o), 32'(valid));
        if (valid) chk({name, "_pc"}, bus.pc_o, pc);
        chk({name, "_inst"}, bus.inst_o, inst);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_req"},   32'(bus.mem_req_o), 32'd0);
        chk({name, "_addr"},  bus.mem_addr_o, RST_PC);
        chk({name, "_pc"},    bus.pc_o, 32'd0);
        chk({name, "_inst"},  bus.inst_o, NOP_INST);
        chk({name, "_valid"}, 32'(bus.inst_valid_o), 32'd0);
        chk({name, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    task automatic chk_state(input string name, input fetch_state_e st);
        chk(name, 32'(dbg_state), 32'(st));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        chk("req_low_edge0", 32'(bus.mem_req_o), 32'd0);
        tick();
        chk("req_high_edge1", 32'(bus.mem_req_o), 32'd1);
        chk("first_addr", bus.mem_addr_o, RST_PC);
    endtask

    initial begin
        rst             = 1'b1;
        bus.stall_i     = 1'b0;
        bus.br_enable_i = 1'b0;
        bus.br_addr_i   = '0;
        #1 rst = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge clk);

        // zero-wait streaming: a new instruction every second cycle
        release_reset();
        tick(); chk_slot("zw_e2", 1'b0, 32'h0, NOP_INST);
        tick(); chk_slot("zw_pc0", 1'b1, 32'h0, 32'hFFFF_FFFF);
        tick(); chk_slot("zw_e4", 1'b0, 32'h0, NOP_INST);
        tick(); chk_slot("zw_pc4", 1'b1, 32'h4, 32'hFFFF_FFFB);
        tick();
        tick(); chk_slot("zw_pc8", 1'b1, 32'h8, 32'hFFFF_FFF7);
        tick();
        tick(); chk_slot("zw_pcc", 1'b1, 32'hC, 32'hFFFF_FFF3);

        // stalled slot: the 0x10 response parks in the hold entry
        bus.stall_i = 1'b1;
        tick(); chk_state("hold_wait", WAIT);
        tick(); chk_state("hold_enter", HOLD);
        chk("hold_no_req", 32'(bus.mem_req_o), 32'd0);
        chk_slot("hold_slot", 1'b1, 32'hC, 32'hFFFF_FFF3);
        tick(); chk_state("hold_stay", HOLD);
        chk("hold_no_req2", 32'(bus.mem_req_o), 32'd0);
        bus.stall_i = 1'b0;
        tick(); chk_slot("hold_drain", 1'b1, 32'h10, 32'hAAAA_AAAA);
        chk("hold_next_req", 32'(bus.mem_req_o), 32'd1);
        chk("hold_next_addr", bus.mem_addr_o, 32'h14);

        // redirect while waiting on a slow response
        rsp_delay = 3;
        tick(); chk_state("kill_wait", WAIT);
        bus.br_enable_i = 1'b1;
        bus.br_addr_i   = 32'h103;
        tick(); bus.br_enable_i = 1'b0;
        chk_state("kill_still_wait", WAIT);
        chk_slot("kill_e15", 1'b0, 32'h0, NOP_INST);
        tick(); chk_state("kill_wait2", WAIT);
        tick(); chk_slot("kill_dropped", 1'b0, 32'h0, NOP_INST);
        chk("kill_req", 32'(bus.mem_req_o), 32'd1);
        chk("kill_addr", bus.mem_addr_o, 32'h100);
        rsp_delay = 1;
        tick(); chk_state("kill_refetch", WAIT);
        tick(); chk_slot("kill_target", 1'b1, 32'h100, 32'hFFFF_FEFF);

        // redirect on the grant edge of 0x20
        gnt_delay       = 2;
        bus.br_enable_i = 1'b1;
        bus.br_addr_i   = 32'h20;
        tick(); bus.br_enable_i = 1'b0;
        chk_slot("gnt_flush", 1'b0, 32'h0, NOP_INST);
        chk("gnt_addr20", bus.mem_addr_o, 32'h20);
        tick(); chk_state("gnt_req", REQ);
        bus.br_enable_i = 1'b1;
        bus.br_addr_i   = 32'h80;
        tick(); bus.br_enable_i = 1'b0;
        chk_state("gnt_killed_wait", WAIT);
        chk("gnt_no_req", 32'(bus.mem_req_o), 32'd0);
        tick(); chk_state("gnt_back_req", REQ);
        chk_slot("gnt_dropped", 1'b0, 32'h0, NOP_INST);
        chk("gnt_addr80", bus.mem_addr_o, 32'h80);
        gnt_delay = 0;
        tick(); chk_state("gnt_wait80", WAIT);
        tick(); chk_slot("gnt_target", 1'b1, 32'h80, 32'hFFFF_FF7F);

        // redirect on the response edge with a full slot
        bus.stall_i = 1'b1;
        tick(); chk_state("rv_wait", WAIT);
        chk_slot("rv_slot", 1'b1, 32'h80, 32'hFFFF_FF7F);
        bus.br_enable_i = 1'b1;
        bus.br_addr_i   = 32'h200;
        tick(); bus.br_enable_i = 1'b0;
        bus.stall_i = 1'b0;
        chk_slot("rv_flush", 1'b0, 32'h0, NOP_INST);
        chk_state("rv_req", REQ);
        chk("rv_addr", bus.mem_addr_o, 32'h200);
        tick(); chk_state("rv_wait200", WAIT);
        tick(); chk_slot("rv_no_kill", 1'b1, 32'h200, 32'hFFFF_FDFF);

        // asynchronous reset in WAIT with a valid slot
        bus.stall_i = 1'b1;
        tick(); chk_state("rst_wait", WAIT);
        chk_slot("rst_slot", 1'b1, 32'h200, 32'hFFFF_FDFF);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("midrst");
        bus.stall_i = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        tick();
        tick(); chk_slot("restart_pc0", 1'b1, 32'h0, 32'hFFFF_FFFF);

        // randomized tail: stalls, memory latency and occasional redirects
        for (int i = 0; i < 300; i++) begin
            bus.stall_i     = ($urandom_range(0, 3) == 0);
            gnt_delay       = $urandom_range(0, 2);
            rsp_delay       = $urandom_range(1, 3);
            bus.br_enable_i = ($urandom_range(0, 19) == 0);
            bus.br_addr_i   = $urandom();
            tick();
        end
        bus.br_enable_i = 1'b0;
        bus.stall_i     = 1'b0;
        repeat (4) tick();
        chk("deliveries_seen", 32'(n_dlv >= 20), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the RISC-V pipeline, feeding the decode stage.
- Owns the PC and issues one instruction-memory read at a time over a request/grant/response handshake.
- Holds each returned instruction with its PC in an output slot until decode accepts it; a one-entry hold buffer covers downstream stalls.
- Applies branch/jump redirects and drops responses from fetches that a redirect has made stale.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_req_o  out  1  fetch request valid.
- mem_addr_o  out  32  fetch address (word aligned, bits [1:0] always 0).
- mem_gnt_i  in  1  memory accepts the request this cycle.
- mem_rvalid_i  in  1  response data valid; arrives at least 1 cycle after grant, responses in order.
- mem_rdata_i  in  32  fetched instruction.
- stall_i  in  1  decode cannot accept the slot this cycle.
- br_enable_i  in  1  redirect fetch this cycle.
- br_addr_i  in  32  redirect target; bits [1:0] ignored and forced to 0.
- pc_o  out  32  PC of the instruction in the slot.
- inst_o  out  32  instruction in the slot; NOP_INST when the slot is empty.
- inst_valid_o  out  1  slot holds a valid instruction.

## Operation
- States:
  - IDLE: first cycle after reset; go to REQ.
  - REQ: mem_req_o=1, mem_addr_o=pc. On mem_gnt_i: req_pc<=pc, pc<=pc+4 (mod 2^32), go to WAIT.
  - WAIT: wait for mem_rvalid_i.
    - If kill is set: drop the data, clear kill, go to REQ.
    - Else if the slot is free (inst_valid_o==0, or being consumed this cycle): load the slot with {req_pc, mem_rdata_i}, go to REQ.
    - Else: load the hold buffer, go to HOLD.
  - HOLD: no request. When the slot is consumed, move the hold buffer into the slot and go to REQ.
- Slot consumption: a rising edge with inst_valid_o=1 and stall_i=0. With no new load that edge, inst_valid_o<=0 and inst_o<=NOP_INST.
- The address presented in REQ may change before grant; memory samples it only on the grant cycle.
- Redirect (br_enable_i=1) has priority over every other event on that edge:
  - pc<=br_addr_i & ~3; inst_valid_o<=0; inst_o<=NOP_INST; hold buffer invalidated.
  - In WAIT without mem_rvalid_i: set kill, stay in WAIT.
  - In WAIT with mem_rvalid_i on the same edge: data dropped, kill stays clear, go to REQ.
  - In REQ with mem_gnt_i on the same edge: the granted fetch is killed (kill set, go to WAIT). pc takes br_addr_i, not pc+4.
  - In REQ without grant: stay in REQ; mem_addr_o shows the new pc next cycle.
  - In HOLD: go to REQ.
- Reset values:
  - state=IDLE, pc=RESET_PC, kill=0, hold buffer invalid.
  - mem_req_o=0, mem_addr_o=RESET_PC.
  - pc_o=0, inst_o=NOP_INST, inst_valid_o=0.

## Timing
- Outputs are registered. mem_req_o and mem_addr_o decode from the state and pc registers only.
- At most one fetch outstanding.
- Zero-wait memory (grant on first request cycle, rvalid 1 cycle after grant) gives one instruction every 2 cycles.
- Latency from mem_rvalid_i to inst_valid_o: 1 edge.
- Reset released at edge 0: mem_req_o is first high in the cycle after edge 1.
- Asserting rst mid-fetch abandons the outstanding fetch. Memory must not return a response for a fetch granted before reset; this is a system-level guarantee, not checked here.

## Structure
- Shared package: NOP_INST = 32'h0000_0013 (addi x0,x0,0), the fetch state enum (IDLE/REQ/WAIT/HOLD), and the InstAddrBus/InstBus widths. Decode uses the same widths.
- Single module. The slot plus hold buffer may be split into sub-module fetch_slot_buf (two-entry in-order buffer with load/consume/flush).

## Test plan
- Reset then zero-wait memory returning mem[a]=a^32'hFFFF_FFFF, stall_i=0: inst_valid_o pulses every 2nd cycle with pc_o 0,4,8 and inst_o = pc_o inverted.
- Slot full, stall_i=1, response 0xAAAA_AAAA for pc 0x10 arrives: enters HOLD with mem_req_o=0. Release stall: slot shows pc 0x10/0xAAAA_AAAA the next cycle, then the fetch of 0x14 is requested.
- br_enable_i=1 with br_addr_i=0x103 while in WAIT: later response is dropped (inst_valid_o stays 0). Next request is at 0x100 and its result appears with pc_o=0x100.
- br_enable_i coincident with mem_gnt_i for pc 0x20, target 0x80: the 0x20 response is dropped, next mem_addr_o=0x80.
- Redirect coincident with mem_rvalid_i and with a valid slot: slot cleared to NOP_INST with inst_valid_o=0, no kill left pending.
- rst asserted low while in WAIT with a valid slot: all outputs at reset values immediately; after release, fetch restarts at RESET_PC.
